// File: rtl/adder_pkg.sv
// Shared constants and types for the 4-bit adder datapath.
// Holds operand width, default accumulator sizing and the accumulator FSM states.
package adder_pkg;

  localparam int OPND_W        = 5;
  localparam int ACC_W_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Sums BURST_LEN 5-bit adder results ({cout,sum}) into an ACC_W-bit total.
// Ports: clk, rst (sync, active-high), sum_in/cout_in/in_valid/in_ready
// (input handshake), clear (abort burst), acc_out/ovf/count/out_valid/
// out_ready (result handshake).
// Macro ACC_SATURATE_EN: overflow clamps to all-ones instead of wrapping.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sum_in,
  input  logic             cout_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [ACC_W-1:0] opnd;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] add_acc;
  logic             add_ovf;
  logic [CNT_W-1:0] count_inc;

  assign accept    = in_valid && in_ready_q;
  assign opnd      = ACC_W'({cout_in, sum_in});
  assign sum_w     = {1'b0, acc_q} + {1'b0, opnd};
  assign add_ovf   = sum_w[ACC_W];
  assign count_inc = count_q + CNT_ONE;

`ifdef ACC_SATURATE_EN
  // Clamped value stays at all-ones: any further non-zero
  // operand overflows again, a zero operand leaves it alone.
  assign add_acc = add_ovf ? '1 : sum_w[ACC_W-1:0];
`else
  assign add_acc = sum_w[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = opnd;
            ovf_d   = 1'b0;
            count_d = CNT_ONE;
            state_d = (BURST_LEN == 1) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_d   = add_acc;
            ovf_d   = ovf_q | add_ovf;
            count_d = count_inc;
            if (count_inc == BURST_CNT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are decodes of the next state, registered,
  // so neither depends combinationally on in_valid/out_ready.
  assign in_ready_d  = (state_d != DONE);
  assign out_valid_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream stage of the 4-bit ripple adder. It consumes each adder result, the 4-bit sum plus carry-out treated as a 5-bit value, under a valid/ready handshake. It accumulates a fixed-length burst of results into a wide register and presents the burst total, with a sticky overflow flag, through an output valid/ready handshake.

## Interface
- ACC_W, 8: accumulator and result width in bits; minimum 5.
- BURST_LEN, 4: number of adder results summed per burst; minimum 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- sum_in  input  4  adder sum bits.
- cout_in  input  1  adder carry-out.
- in_valid  input  1  sum_in/cout_in valid this cycle.
- in_ready  output  1  block accepts a result this cycle.
- clear  input  1  synchronous abort; discards the burst in progress.
- acc_out  output  ACC_W  burst total; meaningful only while out_valid.
- ovf  output  1  sticky overflow/saturation flag for the current burst.
- out_valid  output  1  burst total available.
- out_ready  input  1  consumer takes the total.
- count  output  CNT_W  results accepted in the current burst; CNT_W = $clog2(BURST_LEN+1).

## Operation
- Operand value v = {cout_in, sum_in}, zero-extended to ACC_W (range 0..31).
- Accept event: in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept: acc <= v, count <= 1, ovf <= 0, go to RUN. If BURST_LEN==1, go to DONE instead.
  - RUN: in_ready=1. On accept: acc <= acc + v, count <= count+1. When the new count equals BURST_LEN, go to DONE.
  - DONE: in_ready=0, out_valid=1, acc_out/ovf/count held stable. On out_ready: go to IDLE, count <= 0. acc_out and ovf keep their last values until the next burst starts.
- Arithmetic: compute the sum at ACC_W+1 bits. If bit ACC_W is set, set ovf (sticky within the burst) and wrap (default build) or saturate (see Configuration).
- Priority, highest first: rst, clear, accept/handover.
- clear in any state: IDLE, acc=0, count=0, ovf=0. A simultaneous in_valid is not accepted; in_ready is still 1, so upstream must treat that cycle's data as dropped.
- in_valid while in DONE: ignored, since in_ready=0 and upstream holds its data.
- Reset values: acc_out=0, ovf=0, count=0, out_valid=0, in_ready=0 during the rst cycle, then 1 from the first cycle after rst deasserts. FSM resets to IDLE.

## Timing
- in_ready and out_valid are registered state decodes. Neither has a combinational path from in_valid or out_ready.
- Latency: out_valid asserts the cycle after the BURST_LEN-th accept.
- Throughput: one accept per cycle in IDLE/RUN. Minimum burst period is BURST_LEN+1 cycles when out_ready is held high (BURST_LEN accepts + 1 DONE cycle).
- DONE exits on the same edge that samples out_ready=1. An accept is possible on the next cycle.
- rst asserted mid-burst: all state cleared on that edge and the partial burst is lost.

## Configuration
- ACC_SATURATE_EN defined: on overflow, acc clamps to all-ones ((1<<ACC_W)-1), remains there for the rest of the burst, and ovf=1.
- ACC_SATURATE_EN undefined: on overflow, acc wraps modulo 2^ACC_W and ovf=1.

## Structure
- Shared package adder_pkg:
  - operand width constant OPND_W=5
  - state enum typedef acc_state_t {IDLE, RUN, DONE}
  - default ACC_W/BURST_LEN constants
- Single module. No sub-module is needed because the FSM, counter and adder are small. The burst counter may optionally be factored into burst_counter if it is reused elsewhere.

## Test plan
- Reset: assert rst 2 cycles -> acc_out=0, ovf=0, count=0, out_valid=0. in_ready=1 the cycle after release.
- Basic burst (defaults): values 5, 9, {1,0x3}=19, 0 back-to-back -> out_valid on cycle 5, acc_out=0x21, ovf=0, count=4.
- Overflow, BURST_LEN=16: 16×{1,0xF}=31 -> wrap build acc_out=0xF0, ovf=1; ACC_SATURATE_EN build acc_out=0xFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid -> in_ready=0, outputs stable, no accept. Raise out_ready -> IDLE next cycle, next burst starts fresh.
- Mid-burst clear: accept 7, 7, then clear with in_valid=1, v=3 -> count=0, acc_out=0. Following 4 values of 1 produce acc_out=4.
- Gapped input: in_valid toggling 1,0,1,0,... with value 2 -> acc_out=8 after the 4th accept. count increments only on accepts.
